// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter shared definitions.
// Widths, FSM encoding, ALU function codes and grant selection.
package alu_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int FUNC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [FUNC_W-1:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_AND  = 4'd2,
        FN_OR   = 4'd3,
        FN_XOR  = 4'd4,
        FN_NOR  = 4'd5,
        FN_SLL  = 4'd6,
        FN_SRL  = 4'd7,
        FN_SRA  = 4'd8,
        FN_SLT  = 4'd9,
        FN_SLTU = 4'd10,
        FN_PASA = 4'd11,
        FN_PASB = 4'd12,
        FN_NOTA = 4'd13,
        FN_INC  = 4'd14,
        FN_DEC  = 4'd15
    } alu_func_t;

    // One latched operation: operands, function and owning requester.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [FUNC_W-1:0] func;
        logic              id;
    } op_t;

    // Returns 1 when requester 1 wins the grant.
    // A lone requester always wins; with both pending, round-robin
    // picks the one not served last, fixed priority picks requester 0.
    function automatic logic pick_grant(
        input logic v0,
        input logic v1,
        input logic last,
        input logic rr_en
    );
        logic sel1;
        if (v0 && v1) begin
            sel1 = rr_en ? ~last : 1'b0;
        end else begin
            sel1 = v1;
        end
        return sel1;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ALU16bit: combinational 16-bit ALU used by alu_arbiter.
// All arithmetic of the arbiter lives here.
module ALU16bit
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [FUNC_W-1:0] i_func,
    output logic [DATA_W-1:0] o_y
);

    alu_func_t        w_func;
    logic [3:0]       w_sh;
    logic             w_slt;
    logic             w_sltu;
    logic [DATA_W-1:0] w_y;

    assign w_func = alu_func_t'(i_func);
    assign w_sh   = i_b[3:0];

    // Signed and unsigned compares feeding the set-less-than ops.
    always_comb begin
        w_slt  = $signed(i_a) < $signed(i_b);
        w_sltu = i_a < i_b;
    end

    // Function decode; result defaults to zero.
    always_comb begin
        w_y = '0;
        case (w_func)
            FN_ADD:  w_y = i_a + i_b;
            FN_SUB:  w_y = i_a - i_b;
            FN_AND:  w_y = i_a & i_b;
            FN_OR:   w_y = i_a | i_b;
            FN_XOR:  w_y = i_a ^ i_b;
            FN_NOR:  w_y = ~(i_a | i_b);
            FN_SLL:  w_y = i_a << w_sh;
            FN_SRL:  w_y = i_a >> w_sh;
            FN_SRA:  w_y = $unsigned($signed(i_a) >>> w_sh);
            FN_SLT:  w_y = {{(DATA_W-1){1'b0}}, w_slt};
            FN_SLTU: w_y = {{(DATA_W-1){1'b0}}, w_sltu};
            FN_PASA: w_y = i_a;
            FN_PASB: w_y = i_b;
            FN_NOTA: w_y = ~i_a;
            FN_INC:  w_y = i_a + 16'd1;
            FN_DEC:  w_y = i_a - 16'd1;
            default: w_y = '0;
        endcase
    end

    assign o_y = w_y;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU16bit.
// IDLE grants and latches, EXEC registers the result, RESP holds it.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [FUNC_W-1:0] req0_func,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [FUNC_W-1:0] req1_func,
    output logic              req1_ready,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    op_t               r_op;
    op_t               w_op_in;
    logic              r_last;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] w_alu_y;
    logic              w_any_valid;
    logic              w_sel1;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_grant;
    logic              w_capture;
    logic              w_rsp0_valid;
    logic              w_rsp1_valid;
    logic              w_busy;

    // Winner selection among the currently pending requesters.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        w_sel1      = pick_grant(req0_valid, req1_valid, r_last, RR_EN);
    end

    // Operand mux: the winner's inputs as they stand in the grant cycle.
    always_comb begin
        w_op_in = '0;
        if (w_sel1) begin
            w_op_in.a    = req1_a;
            w_op_in.b    = req1_b;
            w_op_in.func = req1_func;
            w_op_in.id   = 1'b1;
        end else begin
            w_op_in.a    = req0_a;
            w_op_in.b    = req0_b;
            w_op_in.func = req0_func;
            w_op_in.id   = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake outputs.
    // Ready is masked by rst so nothing is accepted while in reset.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_capture    = 1'b0;
        w_rsp0_valid = 1'b0;
        w_rsp1_valid = 1'b0;
        w_busy       = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (w_any_valid && !rst) begin
                    w_grant0    = ~w_sel1;
                    w_grant1    = w_sel1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rsp0_valid = ~r_op.id;
                w_rsp1_valid = r_op.id;
                if (r_op.id ? rsp1_ready : rsp0_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_grant = w_grant0 | w_grant1;

    // Operand registers load only on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op <= '0;
        end else if (w_grant) begin
            r_op <= w_op_in;
        end
    end

    // Round-robin pointer: remembers who was served last.
    // Reset to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_grant1;
        end
    end

    ALU16bit u_alu (
        .i_a    (r_op.a),
        .i_b    (r_op.b),
        .i_func (r_op.func),
        .o_y    (w_alu_y)
    );

    // Result register: captured at the end of EXEC, held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data <= '0;
        end else if (w_capture) begin
            r_rsp_data <= w_alu_y;
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = w_rsp0_valid;
    assign rsp1_valid = w_rsp1_valid;
    assign rsp_data   = r_rsp_data;
    assign busy       = w_busy;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority to requester 0.
REQ-002 clk  input  1  rising-edge clock, one clock domain.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester has an operation pending.
REQ-005 req0_a, req0_b, req1_a, req1_b  input  16 each  ALU operands.
REQ-006 req0_func, req1_func  input  4 each  ALU function code, passed unchanged to ALU16bit.
REQ-007 req0_ready, req1_ready  output  1 each  one-cycle accept pulse.
REQ-008 rsp0_valid, rsp1_valid  output  1 each  result available for that requester.
REQ-009 rsp_data  output  16  result, valid while either rsp*_valid is high.
REQ-010 rsp0_ready, rsp1_ready  input  1 each  requester consumes its result.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-013 IDLE with any reqN_valid high SHALL grant one requester, pulse its reqN_ready for exactly that cycle, latch a/b/func/id into operand registers and go to EXEC.
REQ-014 Handshake SHALL complete in the same cycle: reqN_valid and reqN_ready both high means accepted, and the requester may change its inputs on the next cycle.
REQ-015 With RR_EN=1 and both valid, the grant SHALL go to the requester not granted last; the pointer SHALL update only on a grant.
REQ-016 With RR_EN=0 and both valid, the grant SHALL go to requester 0.
REQ-017 With one valid, that requester SHALL be granted regardless of the pointer.
REQ-018 EXEC SHALL drive ALU16bit from the latched registers only, register its 16-bit output into rsp_data, and go to RESP.
REQ-019 RESP SHALL hold rspN_valid for the latched id and keep rsp_data stable until rspN_ready is high, then go to IDLE.
REQ-020 Latency SHALL be: accept in cycle N, rsp valid from cycle N+2; with rsp_ready tied high, the next grant comes no earlier than N+3.
REQ-021 The rspN_ready of the non-owning requester SHALL be ignored.
REQ-022 reqN_valid SHALL be ignored in EXEC and RESP; no reqN_ready SHALL be asserted outside IDLE.
REQ-023 At most one reqN_ready and at most one rspN_valid SHALL be high in any cycle.
REQ-024 No arithmetic SHALL be performed in this block; the result width is 16 bits as produced by ALU16bit.

Reset
REQ-025 rst SHALL asynchronously force: state IDLE, round-robin pointer to "last = 1" (so requester 0 wins first), operand registers and rsp_data 0, all ready/valid outputs and busy 0.
REQ-026 Reset in mid-operation SHALL discard the in-flight operation without producing a response.
REQ-027 After rst deasserts, the first grant SHALL occur at the first rising edge with a valid request.

Structure
REQ-028 The state encoding (IDLE=0, EXEC=1, RESP=2), the data width 16 and the func width 4 SHALL be shared constants in a common package or include file.
REQ-029 The block SHALL contain exactly one ALU16bit instance as its only sub-module.

Verification
REQ-030 Single request: req0 (a=20, b=38, func=1) -> req0_ready pulses in cycle N; rsp0_valid from N+2 with rsp_data equal to the ALU16bit output for (20,38,1).
REQ-031 Contention, RR_EN=1: both requesters hold valid for four operations -> grants go 0,1,0,1 with no starvation, and each rsp_data matches that requester's operands.
REQ-032 Contention, RR_EN=0: both requesters continuously valid -> only requester 0 is ever granted.
REQ-033 Backpressure: rsp1_ready held low for 5 cycles -> rsp1_valid and rsp_data stay stable, busy stays high, no new req ready is asserted, rsp0_ready is ignored.
REQ-034 Operand change after accept: req0_a goes from 8 to 5 in cycle N+1 -> the result still uses a=8.
REQ-035 Reset mid-EXEC: rst pulsed -> all outputs are 0 immediately, no response is issued, and the next grant goes to requester 0.
